// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sub-word load/store unit over word-only memory; misalignment trap under LSU_MISALIGN_CHECK_EN
// Loads take ACCESS then DONE; stores take ACCESS, WRITE (read-modify-write), then DONE.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misaligned_o,
    output logic                  Mem_Read_o,
    output logic                  Mem_Write_o,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    input  logic [DATA_WIDTH-1:0] Read_Data_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            r_state;
    logic                  r_we;
    logic                  r_err;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_is_byte;
    logic                  w_is_half;
    logic                  w_misaligned;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_aligned;
    logic [DATA_WIDTH-1:0] w_load_val;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_is_byte = (r_funct3 == 3'b000) || (r_funct3 == 3'b100);
    assign w_is_half = (r_funct3 == 3'b001) || (r_funct3 == 3'b101);
    assign w_aligned = {r_addr[DATA_WIDTH-1:2], 2'b00};

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misaligned = (w_is_half && r_addr[0]) ||
                          (!w_is_byte && !w_is_half && (r_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Lane extraction works straight off the memory bus so rdata_o lands at the end of ACCESS.
    always_comb begin
        w_byte = Read_Data_i[{r_addr[1:0], 3'b000} +: 8];
        w_half = Read_Data_i[{r_addr[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_load_val = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_val = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b001:  w_load_val = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b101:  w_load_val = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load_val = Read_Data_i;
        endcase
    end

    always_comb begin
        w_merged = r_word;
        if (w_is_byte) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else if (w_is_half) begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end else begin
            w_merged = r_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_we     <= we_i;
                        r_funct3 <= funct3_i;
                        r_addr   <= addr_i;
                        r_wdata  <= wdata_i;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_word <= Read_Data_i;
                    r_err  <= w_misaligned;
                    if (w_misaligned) begin
                        r_state <= S_DONE;
                    end else if (r_we) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_rdata <= w_load_val;
                        r_state <= S_DONE;
                    end
                end
                S_WRITE: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus strobes decode from state alone so an async reset drops them immediately.
    assign busy_o       = (r_state == S_ACCESS) || (r_state == S_WRITE);
    assign done_o       = (r_state == S_DONE);
    assign misaligned_o = (r_state == S_DONE) && r_err;
    assign Mem_Read_o   = (r_state == S_ACCESS);
    assign Mem_Write_o  = (r_state == S_WRITE);
    assign Address_o    = busy_o ? w_aligned : '0;
    assign Write_Data_o = (r_state == S_WRITE) ? w_merged : '0;
    assign rdata_o      = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a transaction-level reference model
`timescale 1ns/1ps
module tb_load_store_unit;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        busy_o, done_o, misaligned_o, Mem_Read_o, Mem_Write_o;
    logic [31:0] rdata_o, Address_o, Write_Data_o, Read_Data_i;

    int n_total = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
        .rdata_o(rdata_o), .misaligned_o(misaligned_o), .Mem_Read_o(Mem_Read_o),
        .Mem_Write_o(Mem_Write_o), .Address_o(Address_o), .Write_Data_o(Write_Data_o),
        .Read_Data_i(Read_Data_i)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 0) ? 32'hCAFE_F00D : 32'h0123_4567 * (i + 1);
    endfunction

    // Word memory on the bus; 16 words starting at BASE.
    logic [31:0] mem [16];
    logic        mem_ready = 1'b0;
    assign Read_Data_i = mem[Address_o[5:2]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (Mem_Write_o) begin
            mem[Address_o[5:2]] <= Write_Data_o;
        end
    end

    function automatic int op_size(logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic ref_mis(logic [2:0] f3, logic [31:0] a);
        logic on;
        int   sz;
`ifdef LSU_MISALIGN_CHECK_EN
        on = 1'b1;
`else
        on = 1'b0;
`endif
        sz = op_size(f3);
        return on && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] word, logic [2:0] f3, logic [31:0] a);
        int sz;
        int sh;
        logic [31:0] v;
        sz = op_size(f3);
        if (sz == 4) return word;
        sh = (sz == 1) ? 8 * a[1:0] : 16 * a[1];
        v = (word >> sh) & ((sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF);
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(logic [31:0] word, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        int sz;
        int sh;
        logic [31:0] mask;
        sz = op_size(f3);
        if (sz == 4) return wd;
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        sh = (sz == 1) ? 8 * a[1:0] : 16 * a[1];
        return (word & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    // One record per clock cycle of expected bus/handshake activity.
    typedef struct packed {
        logic        acc, busy, done, mis, mrd, mwr;
        logic [31:0] addr, wd, rd;
    } rec_t;

    rec_t        q[$];
    rec_t        cur;
    logic [31:0] exp_mem [16];
    logic        exp_ready = 1'b0;
    logic [31:0] model_rdata = '0;

    always @(posedge clk or negedge reset) begin : model_p
        rec_t r;
        logic [31:0] word;
        logic m;
        if (!exp_ready) begin
            for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
            exp_ready = 1'b1;
        end
        if (!reset) begin
            q.delete();
            model_rdata = '0;
            cur = '0;
            cur.acc = 1'b1;
        end else begin
            if (cur.mwr) exp_mem[cur.addr[5:2]] = cur.wd;
            if (cur.acc && req_i) begin
                word = exp_mem[addr_i[5:2]];
                m = ref_mis(funct3_i, addr_i);
                r = '0; r.busy = 1'b1; r.mrd = 1'b1;
                r.addr = {addr_i[31:2], 2'b00}; r.rd = model_rdata;
                q.push_back(r);
                if (!m && we_i) begin
                    r = '0; r.busy = 1'b1; r.mwr = 1'b1;
                    r.addr = {addr_i[31:2], 2'b00};
                    r.wd = ref_merge(word, funct3_i, addr_i, wdata_i);
                    r.rd = model_rdata;
                    q.push_back(r);
                end
                if (!m && !we_i) model_rdata = ref_load(word, funct3_i, addr_i);
                r = '0; r.done = 1'b1; r.mis = m; r.rd = model_rdata;
                q.push_back(r);
            end
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = '0; cur.acc = 1'b1; cur.rd = model_rdata;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && reset) begin
            chk("busy", {31'd0, busy_o}, {31'd0, cur.busy});
            chk("done", {31'd0, done_o}, {31'd0, cur.done});
            chk("misaligned", {31'd0, misaligned_o}, {31'd0, cur.mis});
            chk("mem_read", {31'd0, Mem_Read_o}, {31'd0, cur.mrd});
            chk("mem_write", {31'd0, Mem_Write_o}, {31'd0, cur.mwr});
            chk("address", Address_o, cur.addr);
            chk("write_data", Write_Data_o, cur.wd);
            chk("rdata", rdata_o, cur.rd);
        end
    end

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic mis);
        @(posedge clk); #1;
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        @(posedge clk); #1;
        req_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 8) begin
            if ($urandom_range(0, 3) == 0) begin
                req_i = 1'b1; we_i = 1'($urandom); funct3_i = 3'($urandom);
                addr_i = BASE + $urandom_range(0, 63); wdata_i = $urandom;
            end else begin
                req_i = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        mis = misaligned_o;
        req_i = 1'b0;
        chk("op_done", {31'd0, done_o}, 32'd1);
    endtask

    int          lat;
    logic        mis;
    int          n_rd, n_dn;
    logic [31:0] old_word;
    logic [2:0]  f3s [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_mis", {31'd0, misaligned_o}, 32'd0);
        chk("rst_mrd", {31'd0, Mem_Read_o}, 32'd0);
        chk("rst_mwr", {31'd0, Mem_Write_o}, 32'd0);
        chk("rst_addr", Address_o, 32'd0);
        chk("rst_wdata", Write_Data_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        reset = 1'b1;
        chk_en = 1'b1;

        do_op(1'b1, 3'b010, BASE + 4, 32'hDEAD_BEEF, lat, mis);
        chk("sw_lat", lat, 3);
        chk("sw_mem", mem[1], 32'hDEAD_BEEF);
        do_op(1'b0, 3'b010, BASE + 4, 32'h0, lat, mis);
        chk("lw_lat", lat, 2);
        chk("lw_val", rdata_o, 32'hDEAD_BEEF);

        do_op(1'b1, 3'b000, BASE + 5, 32'hAAAA_AA7F, lat, mis);
        chk("sb_mem", mem[1], 32'hDEAD_7FEF);
        do_op(1'b0, 3'b000, BASE + 7, 32'h0, lat, mis);
        chk("lb_val", rdata_o, 32'hFFFF_FFDE);
        do_op(1'b0, 3'b100, BASE + 7, 32'h0, lat, mis);
        chk("lbu_val", rdata_o, 32'h0000_00DE);

        do_op(1'b1, 3'b001, BASE + 6, 32'h5555_8001, lat, mis);
        chk("sh_mem", mem[1], 32'h8001_7FEF);
        do_op(1'b0, 3'b001, BASE + 6, 32'h0, lat, mis);
        chk("lh_val", rdata_o, 32'hFFFF_8001);
        do_op(1'b0, 3'b101, BASE + 6, 32'h0, lat, mis);
        chk("lhu_val", rdata_o, 32'h0000_8001);

        do_op(1'b0, 3'b010, BASE + 2, 32'h0, lat, mis);
        chk("unal_lat", lat, 2);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("unal_flag", {31'd0, mis}, 32'd1);
        chk("unal_rdata", rdata_o, 32'h0000_8001);
`else
        chk("unal_flag", {31'd0, mis}, 32'd0);
        chk("unal_rdata", rdata_o, 32'hCAFE_F00D);
`endif

        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = BASE; wdata_i = 32'h0;
        n_rd = 0; n_dn = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (Mem_Read_o) n_rd++;
            if (done_o) n_dn++;
        end
        req_i = 1'b0;
        chk("hold_reads", n_rd, 3);
        chk("hold_dones", n_dn, 3);
        chk("hold_rdata", rdata_o, 32'hCAFE_F00D);

        for (int k = 0; k < 300; k++) begin
            rwe = 1'($urandom);
            rf3 = f3s[$urandom_range(0, 7)];
            raddr = BASE + $urandom_range(0, 63);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(rwe, rf3, raddr, $urandom, lat, mis);
            chk("rand_lat", lat, (ref_mis(rf3, raddr) || !rwe) ? 2 : 3);
        end

        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = BASE + 8; wdata_i = 32'h1234_5678;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_wr_before", {31'd0, Mem_Write_o}, 32'd1);
        old_word = exp_mem[2];
        chk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_wr_drop", {31'd0, Mem_Write_o}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_mem", mem[2], old_word);
        chk("rst_mid_rdata", rdata_o, 32'd0);
        chk("rst_mid_done", {31'd0, done_o}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        do_op(1'b0, 3'b010, BASE + 8, 32'h0, lat, mis);
        chk("post_rst_load", rdata_o, old_word);

        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], exp_mem[i]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
